// File: rtl/seg14_pkg.sv
// Shared constants for the 14-segment scrolling display: sizes, character codes and glyphs.
// Glyph bit order is a,b,c,d,e,f,g1,g2,h,i,j,k,l,m from bit 13 down to bit 0.
package seg14_pkg;

  localparam int unsigned NUM_DIG   = 12;
  localparam int unsigned BUF_DEPTH = 32;
  localparam int unsigned CODE_W    = 6;
  localparam int unsigned GLYPH_W   = 14;
  localparam int unsigned ADDR_W    = 5;

  localparam logic [CODE_W-1:0] CH_SPACE = 6'd0;
  localparam logic [CODE_W-1:0] CH_A     = 6'd1;
  localparam logic [CODE_W-1:0] CH_Z     = 6'd26;
  localparam logic [CODE_W-1:0] CH_DIG0  = 6'd27;
  localparam logic [CODE_W-1:0] CH_DIG9  = 6'd36;

  localparam logic [GLYPH_W-1:0] GLYPH_BLANK = 14'b00000000000000;
  localparam logic [GLYPH_W-1:0] GLYPH_A     = 14'b11101111000000;
  localparam logic [GLYPH_W-1:0] GLYPH_B     = 14'b11110001010010;
  localparam logic [GLYPH_W-1:0] GLYPH_C     = 14'b10011100000000;
  localparam logic [GLYPH_W-1:0] GLYPH_D     = 14'b11110000010010;
  localparam logic [GLYPH_W-1:0] GLYPH_E     = 14'b10011110000000;
  localparam logic [GLYPH_W-1:0] GLYPH_F     = 14'b10001110000000;
  localparam logic [GLYPH_W-1:0] GLYPH_G     = 14'b10111101000000;
  localparam logic [GLYPH_W-1:0] GLYPH_H     = 14'b01101111000000;
  localparam logic [GLYPH_W-1:0] GLYPH_I     = 14'b10010000010010;
  localparam logic [GLYPH_W-1:0] GLYPH_J     = 14'b01111000000000;
  localparam logic [GLYPH_W-1:0] GLYPH_K     = 14'b00001110001100;
  localparam logic [GLYPH_W-1:0] GLYPH_L     = 14'b00011100000000;
  localparam logic [GLYPH_W-1:0] GLYPH_M     = 14'b01101100101000;
  localparam logic [GLYPH_W-1:0] GLYPH_N     = 14'b01101100100100;
  localparam logic [GLYPH_W-1:0] GLYPH_O     = 14'b11111100000000;
  localparam logic [GLYPH_W-1:0] GLYPH_P     = 14'b11001111000000;
  localparam logic [GLYPH_W-1:0] GLYPH_Q     = 14'b11111100000100;
  localparam logic [GLYPH_W-1:0] GLYPH_R     = 14'b11001111000100;
  localparam logic [GLYPH_W-1:0] GLYPH_S     = 14'b10110111000000;
  localparam logic [GLYPH_W-1:0] GLYPH_T     = 14'b10000000010010;
  localparam logic [GLYPH_W-1:0] GLYPH_U     = 14'b01111100000000;
  localparam logic [GLYPH_W-1:0] GLYPH_V     = 14'b00001100001001;
  localparam logic [GLYPH_W-1:0] GLYPH_W_CH  = 14'b01101100000101;
  localparam logic [GLYPH_W-1:0] GLYPH_X     = 14'b00000000101101;
  localparam logic [GLYPH_W-1:0] GLYPH_Y     = 14'b00000000101010;
  localparam logic [GLYPH_W-1:0] GLYPH_Z     = 14'b10010000001001;
  localparam logic [GLYPH_W-1:0] GLYPH_ZERO  = 14'b11111100001001;
  localparam logic [GLYPH_W-1:0] GLYPH_ONE   = 14'b01100000001000;
  localparam logic [GLYPH_W-1:0] GLYPH_TWO   = 14'b11011011000000;
  localparam logic [GLYPH_W-1:0] GLYPH_THREE = 14'b11110001000000;
  localparam logic [GLYPH_W-1:0] GLYPH_FOUR  = 14'b01100111000000;
  localparam logic [GLYPH_W-1:0] GLYPH_FIVE  = 14'b10110111000000;
  localparam logic [GLYPH_W-1:0] GLYPH_SIX   = 14'b10111111000000;
  localparam logic [GLYPH_W-1:0] GLYPH_SEVEN = 14'b11100000000000;
  localparam logic [GLYPH_W-1:0] GLYPH_EIGHT = 14'b11111111000000;
  localparam logic [GLYPH_W-1:0] GLYPH_NINE  = 14'b11110111000000;

endpackage

// File: rtl/seg14_font.sv
// Character code to 14-segment glyph lookup; codes outside A..Z and 0..9 are dark.
module seg14_font
  import seg14_pkg::*;
(
  input  logic [CODE_W-1:0]  code,
  output logic [GLYPH_W-1:0] glyph_c
);

  always_comb begin
    glyph_c = GLYPH_BLANK;
    case (code)
      6'd1:  glyph_c = GLYPH_A;
      6'd2:  glyph_c = GLYPH_B;
      6'd3:  glyph_c = GLYPH_C;
      6'd4:  glyph_c = GLYPH_D;
      6'd5:  glyph_c = GLYPH_E;
      6'd6:  glyph_c = GLYPH_F;
      6'd7:  glyph_c = GLYPH_G;
      6'd8:  glyph_c = GLYPH_H;
      6'd9:  glyph_c = GLYPH_I;
      6'd10: glyph_c = GLYPH_J;
      6'd11: glyph_c = GLYPH_K;
      6'd12: glyph_c = GLYPH_L;
      6'd13: glyph_c = GLYPH_M;
      6'd14: glyph_c = GLYPH_N;
      6'd15: glyph_c = GLYPH_O;
      6'd16: glyph_c = GLYPH_P;
      6'd17: glyph_c = GLYPH_Q;
      6'd18: glyph_c = GLYPH_R;
      6'd19: glyph_c = GLYPH_S;
      6'd20: glyph_c = GLYPH_T;
      6'd21: glyph_c = GLYPH_U;
      6'd22: glyph_c = GLYPH_V;
      6'd23: glyph_c = GLYPH_W_CH;
      6'd24: glyph_c = GLYPH_X;
      6'd25: glyph_c = GLYPH_Y;
      6'd26: glyph_c = GLYPH_Z;
      6'd27: glyph_c = GLYPH_ZERO;
      6'd28: glyph_c = GLYPH_ONE;
      6'd29: glyph_c = GLYPH_TWO;
      6'd30: glyph_c = GLYPH_THREE;
      6'd31: glyph_c = GLYPH_FOUR;
      6'd32: glyph_c = GLYPH_FIVE;
      6'd33: glyph_c = GLYPH_SIX;
      6'd34: glyph_c = GLYPH_SEVEN;
      6'd35: glyph_c = GLYPH_EIGHT;
      6'd36: glyph_c = GLYPH_NINE;
      default: glyph_c = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/seg14_scroll_ctrl.sv
// 12-digit multiplexed 14-segment controller with a 32-character buffer and
// optional circular scrolling; message length and mode are sampled once per frame.
module seg14_scroll_ctrl
  import seg14_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 4,
  parameter int unsigned FRAMES_PER_STEP = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [CODE_W-1:0]   wr_char,
  input  logic [5:0]          msg_len,
  input  logic                scroll_en,
  input  logic                blank,
  output logic [NUM_DIG-1:0]  sel,
  output logic [GLYPH_W-1:0]  segm,
  output logic                frame_pulse
);

  localparam int unsigned SCAN_W = 8;
  localparam int unsigned FCNT_W = 8;
  localparam int unsigned DIG_W  = 4;
  localparam int unsigned LEN_W  = 6;
  localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [FCNT_W-1:0] FRAME_LAST = FCNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [DIG_W-1:0]  DIG_LAST   = DIG_W'(NUM_DIG - 1);
  localparam logic [LEN_W-1:0]  LEN_MAX    = LEN_W'(BUF_DEPTH);

  logic [SCAN_W-1:0]  scan_q, scan_d;
  logic [DIG_W-1:0]   digit_q, digit_d;
  logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [ADDR_W-1:0]  offset_q, offset_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               scroll_q, scroll_d;
  logic [NUM_DIG-1:0] sel_q, sel_d;
  logic [GLYPH_W-1:0] segm_q, segm_d;
  logic               frame_pulse_q, frame_pulse_d;
  logic [CODE_W-1:0]  char_mem_q [BUF_DEPTH];

  logic               frame_start, scan_wrap, frame_end, char_valid;
  logic [LEN_W-1:0]   len_clamp, len_cur;
  logic               scroll_cur;
  logic [ADDR_W-1:0]  offset_cur, idx_cur, rd_addr;
  logic [CODE_W-1:0]  rd_char;
  logic [GLYPH_W-1:0] glyph_c;

  // Read-before-write: a same-cycle write is seen from the next read onward.
  assign rd_char = char_mem_q[rd_addr];

  seg14_font u_font (
    .code    (rd_char),
    .glyph_c (glyph_c)
  );

  always_comb begin
    frame_start = (scan_q == '0) && (digit_q == '0);
    scan_wrap   = (scan_q == SCAN_LAST);
    frame_end   = scan_wrap && (digit_q == DIG_LAST);
    len_clamp   = (msg_len > LEN_MAX) ? LEN_MAX : msg_len;

    // Frame-start values are used directly so digit 0 already reflects the new frame.
    len_cur    = frame_start ? len_clamp : len_q;
    scroll_cur = frame_start ? scroll_en : scroll_q;
    offset_cur = offset_q;
    if (frame_start && (!scroll_en || ({1'b0, offset_q} >= len_clamp))) begin
      offset_cur = '0;
    end
    idx_cur    = frame_start ? offset_cur : idx_q;
    rd_addr    = scroll_cur ? idx_cur : ADDR_W'(digit_q);
    char_valid = (len_cur != '0) && (scroll_cur || ({2'b00, digit_q} < len_cur));

    scan_d        = scan_wrap ? '0 : SCAN_W'(scan_q + SCAN_W'(1));
    digit_d       = digit_q;
    idx_d         = idx_cur;
    len_d         = len_cur;
    scroll_d      = scroll_cur;
    offset_d      = offset_cur;
    frame_cnt_d   = frame_cnt_q;
    sel_d         = blank ? '0 : (NUM_DIG'(1) << digit_q);
    segm_d        = (blank || !char_valid) ? GLYPH_BLANK : glyph_c;
    frame_pulse_d = frame_start;

    if (scan_wrap) begin
      digit_d = (digit_q == DIG_LAST) ? '0 : DIG_W'(digit_q + DIG_W'(1));
      idx_d   = (({1'b0, idx_cur} + LEN_W'(1)) >= len_cur) ? '0 : ADDR_W'(idx_cur + ADDR_W'(1));
    end

    // Scroll step is decided on the last cycle of a frame, applied at the next start.
    if (frame_end) begin
      if (scroll_q) begin
        if (frame_cnt_q == FRAME_LAST) begin
          frame_cnt_d = '0;
          offset_d    = (({1'b0, offset_q} + LEN_W'(1)) >= len_q) ? '0
                                                                  : ADDR_W'(offset_q + ADDR_W'(1));
        end else begin
          frame_cnt_d = FCNT_W'(frame_cnt_q + FCNT_W'(1));
        end
      end else begin
        frame_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q        <= '0;
      digit_q       <= '0;
      frame_cnt_q   <= '0;
      offset_q      <= '0;
      idx_q         <= '0;
      len_q         <= '0;
      scroll_q      <= 1'b0;
      sel_q         <= '0;
      segm_q        <= '0;
      frame_pulse_q <= 1'b0;
    end else begin
      scan_q        <= scan_d;
      digit_q       <= digit_d;
      frame_cnt_q   <= frame_cnt_d;
      offset_q      <= offset_d;
      idx_q         <= idx_d;
      len_q         <= len_d;
      scroll_q      <= scroll_d;
      sel_q         <= sel_d;
      segm_q        <= segm_d;
      frame_pulse_q <= frame_pulse_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        char_mem_q[i] <= CH_SPACE;
      end
    end else if (wr_en) begin
      char_mem_q[wr_addr] <= wr_char;
    end
  end

  assign sel         = sel_q;
  assign segm        = segm_q;
  assign frame_pulse = frame_pulse_q;

endmodule

// File: tb/tb_seg14_scroll_ctrl.sv
// Directed bench for seg14_scroll_ctrl with a cycle-level reference model feeding a scoreboard.
module tb_seg14_scroll_ctrl;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned FPS      = 2;

  localparam logic [13:0] R_A    = 14'b11101111000000;
  localparam logic [13:0] R_D    = 14'b11110000010010;
  localparam logic [13:0] R_E    = 14'b10011110000000;
  localparam logic [13:0] R_I    = 14'b10010000010010;
  localparam logic [13:0] R_L    = 14'b00011100000000;
  localparam logic [13:0] R_N    = 14'b01101100100100;
  localparam logic [13:0] R_ZERO = 14'b11111100001001;
  localparam logic [13:0] R_ONE  = 14'b01100000001000;

  logic        clk = 1'b0;
  logic        rst, wr_en, scroll_en, blank;
  logic [4:0]  wr_addr;
  logic [5:0]  wr_char, msg_len;
  logic [11:0] sel;
  logic [13:0] segm;
  logic        frame_pulse;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [11:0] sel;
    logic [13:0] segm;
    logic        fp;
  } exp_t;
  exp_t sb_q[$];

  int         m_scan, m_digit, m_len, m_off, m_fcnt;
  bit         m_scroll;
  logic [5:0] m_buf [32];

  seg14_scroll_ctrl #(.SCAN_DIV(SCAN_DIV), .FRAMES_PER_STEP(FPS)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_char     (wr_char),
    .msg_len     (msg_len),
    .scroll_en   (scroll_en),
    .blank       (blank),
    .sel         (sel),
    .segm        (segm),
    .frame_pulse (frame_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] ref_glyph(input logic [5:0] c);
    case (c)
      6'd1:    return R_A;
      6'd4:    return R_D;
      6'd5:    return R_E;
      6'd9:    return R_I;
      6'd12:   return R_L;
      6'd14:   return R_N;
      6'd27:   return R_ZERO;
      6'd28:   return R_ONE;
      default: return 14'h0;
    endcase
  endfunction

  // Predict the next registered outputs from the inputs now applied, then clock and compare.
  task automatic tick();
    exp_t e;
    bit   fs, valid;
    int   ch;
    if (rst) begin
      m_scan = 0; m_digit = 0; m_len = 0; m_off = 0; m_fcnt = 0; m_scroll = 0;
      for (int i = 0; i < 32; i++) m_buf[i] = 6'd0;
      e.sel = 12'h0; e.segm = 14'h0; e.fp = 1'b0;
    end else begin
      fs = (m_scan == 0) && (m_digit == 0);
      if (fs) begin
        m_len    = (msg_len > 6'd32) ? 32 : int'(msg_len);
        m_scroll = scroll_en;
        if (!m_scroll || m_off >= m_len) m_off = 0;
      end
      valid = (m_len != 0) && (m_scroll || m_digit < m_len);
      ch    = (m_scroll && valid) ? (m_off + m_digit) % m_len : m_digit;
      e.sel  = blank ? 12'h0 : (12'(1) << m_digit);
      e.segm = (blank || !valid) ? 14'h0 : ref_glyph(m_buf[ch]);
      e.fp   = fs;
      if (wr_en) m_buf[wr_addr] = wr_char;
      if (m_scan == SCAN_DIV - 1) begin
        if (m_digit == 11) begin
          if (m_scroll) begin
            m_fcnt++;
            if (m_fcnt == FPS) begin
              m_fcnt = 0;
              m_off  = (m_len == 0) ? 0 : (m_off + 1) % m_len;
            end
          end else begin
            m_fcnt = 0;
          end
        end
        m_digit = (m_digit + 1) % 12;
        m_scan  = 0;
      end else begin
        m_scan++;
      end
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++;
    assert (sel === e.sel) else begin
      errors++; $error("FAIL sb_sel: observed=%h expected=%h", sel, e.sel);
    end
    checks++;
    assert (segm === e.segm) else begin
      errors++; $error("FAIL sb_segm: observed=%b expected=%b", segm, e.segm);
    end
    checks++;
    assert (frame_pulse === e.fp) else begin
      errors++; $error("FAIL sb_frame_pulse: observed=%b expected=%b", frame_pulse, e.fp);
    end
  endtask

  task automatic wait_frames(input int n);
    for (int f = 0; f < n; f++) begin
      int b = 0;
      do begin tick(); b++; end while (frame_pulse !== 1'b1 && b < 200);
      checks++;
      assert (frame_pulse === 1'b1) else begin
        errors++; $error("FAIL frame_wait: observed=%b expected=1", frame_pulse);
      end
    end
  endtask

  task automatic check_digit(input int k, input logic [13:0] g, input string tag);
    logic [11:0] want;
    int b = 0;
    want = 12'(1) << k;
    do begin tick(); b++; end while (sel !== want && b < 100);
    checks++;
    assert (sel === want && segm === g) else begin
      errors++; $error("FAIL %s: observed sel=%h segm=%b expected sel=%h segm=%b",
                       tag, sel, segm, want, g);
    end
  endtask

  task automatic write_char(input logic [4:0] a, input logic [5:0] c);
    wr_en = 1'b1; wr_addr = a; wr_char = c;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    logic [5:0] name [6];
    int b;
    name[0] = 6'd4; name[1] = 6'd1; name[2] = 6'd14;
    name[3] = 6'd9; name[4] = 6'd5; name[5] = 6'd12;

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_char = '0;
    msg_len = '0; scroll_en = 1'b0; blank = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    assert (sel === 12'h001 && frame_pulse === 1'b1) else begin
      errors++; $error("FAIL reset_release: observed sel=%h fp=%b expected sel=001 fp=1", sel, frame_pulse);
    end
    repeat (SCAN_DIV) tick();
    checks++;
    assert (sel === 12'h002) else begin
      errors++; $error("FAIL scan_digit1: observed=%h expected=002", sel);
    end

    // Static text "DANIEL"
    for (int i = 0; i < 6; i++) write_char(5'(i), name[i]);
    msg_len = 6'd6;
    wait_frames(2);
    checks++;
    assert (segm === R_D) else begin
      errors++; $error("FAIL static_d0: observed=%b expected=%b", segm, R_D);
    end
    check_digit(1, R_A, "static_d1");
    check_digit(6, 14'h0, "static_d6");
    check_digit(11, 14'h0, "static_d11");

    // Blanking during digit 3
    check_digit(3, R_I, "pre_blank_d3");
    blank = 1'b1;
    tick();
    checks++;
    assert (sel === 12'h000 && segm === 14'h0) else begin
      errors++; $error("FAIL blank_on: observed sel=%h segm=%b expected 000/0", sel, segm);
    end
    repeat (9) tick();
    blank = 1'b0;
    wait_frames(1);

    // Scrolling
    scroll_en = 1'b1;
    wait_frames(1);
    wait_frames(1);
    checks++;
    assert (segm === R_D) else begin
      errors++; $error("FAIL scroll_f0_d0: observed=%b expected=%b", segm, R_D);
    end
    check_digit(6, R_D, "scroll_f0_d6_wrap");
    wait_frames(2);
    checks++;
    assert (segm === R_A) else begin
      errors++; $error("FAIL scroll_f2_d0: observed=%b expected=%b", segm, R_A);
    end
    check_digit(5, R_D, "scroll_f2_d5");
    wait_frames(10);
    checks++;
    assert (segm === R_D) else begin
      errors++; $error("FAIL scroll_f12_d0: observed=%b expected=%b", segm, R_D);
    end

    // Length boundaries
    scroll_en = 1'b0;
    msg_len   = 6'd0;
    wait_frames(2);
    check_digit(4, 14'h0, "len0_d4");
    check_digit(0, 14'h0, "len0_d0");
    write_char(5'd10, 6'd27);
    write_char(5'd31, 6'd28);
    msg_len = 6'd40;
    wait_frames(2);
    check_digit(10, R_ZERO, "len40_d10");
    scroll_en = 1'b1;
    wait_frames(6);
    msg_len = 6'd32;
    wait_frames(4);

    // Shrink 6 -> 2 while offset is 4
    msg_len = 6'd6;
    b = 0;
    while (m_off != 4 && b < 4000) begin tick(); b++; end
    checks++;
    assert (m_off == 4) else begin
      errors++; $error("FAIL offset4_timeout: observed=%0d expected=4", m_off);
    end
    msg_len = 6'd2;
    wait_frames(1);
    checks++;
    assert (segm === R_D) else begin
      errors++; $error("FAIL shrink_d0: observed=%b expected=%b", segm, R_D);
    end
    check_digit(1, R_A, "shrink_d1");
    check_digit(2, R_D, "shrink_d2");

    // Write address 0 on the last cycle of digit 0
    scroll_en = 1'b0;
    msg_len   = 6'd6;
    wait_frames(2);
    b = 0;
    while (!(m_digit == 0 && m_scan == SCAN_DIV - 1) && b < 10) begin tick(); b++; end
    write_char(5'd0, 6'd5);
    checks++;
    assert (segm === R_D) else begin
      errors++; $error("FAIL write_old_glyph: observed=%b expected=%b", segm, R_D);
    end
    wait_frames(1);
    checks++;
    assert (segm === R_E) else begin
      errors++; $error("FAIL write_new_glyph: observed=%b expected=%b", segm, R_E);
    end

    // Reset mid-frame
    check_digit(5, R_L, "pre_rst_d5");
    rst = 1'b1;
    tick();
    checks++;
    assert (sel === 12'h0 && segm === 14'h0 && frame_pulse === 1'b0) else begin
      errors++; $error("FAIL midframe_rst: observed sel=%h segm=%b fp=%b expected 0/0/0", sel, segm, frame_pulse);
    end
    rst = 1'b0;
    tick();
    checks++;
    assert (sel === 12'h001 && frame_pulse === 1'b1) else begin
      errors++; $error("FAIL rst_restart: observed sel=%h fp=%b expected 001/1", sel, frame_pulse);
    end
    check_digit(2, 14'h0, "rst_buf_space_d2");
    wait_frames(1);
    checks++;
    assert (segm === 14'h0) else begin
      errors++; $error("FAIL rst_buf_space_d0: observed=%b expected=0", segm);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg14_scroll_ctrl.md
SEG14_SCROLL_CTRL -- requirements
Module: seg14_scroll_ctrl

Interface
REQ-001 Parameters:
- SCAN_DIV, default 4 -- clock cycles each digit is held; 1..256.
- FRAMES_PER_STEP, default 8 -- full 12-digit frames per scroll step; 1..256.
REQ-002 clk  input  1  -- single clock; all logic is on its rising edge.
REQ-003 rst  input  1  -- reset, synchronous, active-high.
REQ-004 wr_en  input  1  -- character-buffer write strobe.
REQ-005 wr_addr  input  5  -- buffer write address, 0..31.
REQ-006 wr_char  input  6  -- character code to write.
REQ-007 msg_len  input  6  -- message length; 0 = blank; values >32 are clamped to 32.
REQ-008 scroll_en  input  1  -- enables scrolling.
REQ-009 blank  input  1  -- forces the display dark.
REQ-010 sel  output  12  -- one-hot digit select; bit k = digit k.
REQ-011 segm  output  14  -- glyph for the selected digit; bit13 = segment a.
REQ-012 frame_pulse  output  1  -- one-cycle pulse, high on every cycle in which sel becomes 12'h001.

Function
REQ-013 Character codes: 0 = space; 1..26 = A..Z; 27..36 = digits 0..9; 37..63 = space (glyph 14'b0).
REQ-014 Character buffer:
- 32 x 6 bits.
- When wr_en is high, wr_char is written to wr_addr on the clock edge.
- A read of the same address in the same cycle returns the old value.
REQ-015 Scan counters:
- scan_cnt counts 0..SCAN_DIV-1.
- digit_cnt advances 0..11 and wraps to 0 when scan_cnt wraps.
- One frame = 12*SCAN_DIV cycles.
REQ-016 Output registers: sel and segm are registered one cycle after digit_cnt/scan_cnt.
- sel = one-hot(digit_cnt).
- segm = glyph of the character selected for that digit.
REQ-017 Frame start: at digit_cnt=0, scan_cnt=0, the block latches len_l = clamp(msg_len) and latches the current scroll_en value.
REQ-018 Static mode (latched scroll_en=0):
- Digit k shows buf[k] if k < len_l, otherwise space.
- offset is forced to 0 at the frame start.
REQ-019 Scroll mode (latched scroll_en=1):
- Digit k shows buf[(offset+k) mod len_l].
- The index is computed incrementally: idx is loaded with offset at frame start, increments on each digit advance, and wraps from len_l-1 to 0.
- No divider is used.
REQ-020 Scroll step:
- frame_cnt counts completed frames while in scroll mode.
- At FRAMES_PER_STEP frames, frame_cnt resets to 0 and offset = (offset == len_l-1) ? 0 : offset+1.
- The new offset takes effect from the next frame start.
REQ-021 If len_l = 0, segm = 0 for all digits and offset stays at 0.
- If offset >= len_l after msg_len shrinks, offset is reset to 0 at the frame start.
REQ-022 Blanking:
- blank=1 forces sel=0 and segm=0 on the next registered cycle.
- Counters, offset and frame_pulse continue unaffected.
- When blank is released, output resumes at the current digit.
REQ-023 All data changes (msg_len, scroll_en) take effect only at a frame start; buffer writes are visible on the next read of that address.

Reset
REQ-024 While rst is high at a clock edge, the following are all cleared to 0: sel, segm, frame_pulse, scan_cnt, digit_cnt, frame_cnt, offset, idx, len_l, every buffer entry.
REQ-025 The first edge with rst low registers digit 0: sel=12'h001 and frame_pulse=1.
REQ-026 A reset asserted mid-frame takes effect on that edge; no partial frame completes.

Structure
REQ-027 Package seg14_pkg shall hold:
- NUM_DIG=12, BUF_DEPTH=32.
- Character-code localparams.
- 14-bit glyph constants, e.g. A=14'b11101111000000, D=14'b11110000010010, E=14'b10011110000000, I=14'b10010000010010, L=14'b00011100000000, N=14'b01101100100100, S=14'b10110111000000, ONE=14'b01100000001000, ZERO=14'b11111100001001.
REQ-028 One combinational sub-module, seg14_font, shall map the 6-bit code to the 14-bit glyph; it is instantiated once.

Verification (SCAN_DIV=4, FRAMES_PER_STEP=2)
REQ-029 Reset and scan:
- Stimulus: rst high for 3 cycles, then low.
- Response: sel=0 and segm=0 during reset; sel=12'h001 and frame_pulse=1 on the first edge after release; sel=12'h002 4 cycles later; frame_pulse repeats every 48 cycles.
REQ-030 Static text:
- Stimulus: write codes 4,1,14,9,5,12 ("DANIEL") to addresses 0..5; msg_len=6; scroll_en=0.
- Response: digit0 segm=14'b11110000010010; digit1 segm=14'b11101111000000; digits 6..11 segm=0.
REQ-031 Scroll:
- Stimulus: same buffer contents, scroll_en=1.
- Response: after 2 frames digit0=A and digit5=D; after 12 frames offset wraps to 0 and digit0=D again; digit6=D in frame 0 (in-frame wrap).
REQ-032 Blanking:
- Stimulus: blank=1 during digit 3 for 10 cycles.
- Response: sel=0 on the next cycle; on release, sel shows the digit reached by the free-running counter; frame_pulse period unchanged.
REQ-033 Length boundaries:
- Stimulus: msg_len=0.
- Response: sel scans, segm=0 on all digits.
- Stimulus: msg_len=40.
- Response: behaves exactly as msg_len=32.
- Stimulus: shrink msg_len 6 to 2 with offset 4.
- Response: offset=0 at the next frame start.
REQ-034 Mid-operation events:
- Stimulus: write addr 0 during the digit-0 read.
- Response: the old glyph is shown that frame, the new glyph the next frame.
- Stimulus: rst mid-frame.
- Response: all outputs are 0 on the next edge and the buffer reads as spaces.
